// File: rtl/dtlb_miss_fill.sv
// DTLB miss queue with deduplication and a page-walk request / TLB refill sequencer.
// Misses are queued in a small circular FIFO and walked one at a time.
`ifndef dtlbData_width
`define dtlbData_width 64
`endif

module dtlb_miss_fill #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = `dtlbData_width
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_en,
  input  logic [50:0]           miss_addr,
  output logic                  miss_full,
  output logic                  miss_ovf,
  output logic                  walk_req_valid,
  input  logic                  walk_req_ready,
  output logic [50:0]           walk_req_addr,
  input  logic                  walk_rsp_valid,
  input  logic [DATA_WIDTH-1:0] walk_rsp_data0,
  input  logic [DATA_WIDTH-1:0] walk_rsp_data1,
  input  logic [DATA_WIDTH-1:0] walk_rsp_data2,
  input  logic                  walk_rsp_fault,
  output logic [50:0]           tlb_write_addr,
  output logic [DATA_WIDTH-1:0] tlb_write_data0,
  output logic [DATA_WIDTH-1:0] tlb_write_data1,
  output logic [DATA_WIDTH-1:0] tlb_write_data2,
  output logic                  tlb_write_wen,
  output logic                  tlb_write_invl,
  output logic                  tlb_write_xstant,
  input  logic                  flush,
  output logic                  busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    WRITE = 2'd3
  } state_e;

  state_e                state_q;
  logic [50:0]           mem_q [DEPTH];
  logic [PW-1:0]         rd_ptr_q;
  logic [PW-1:0]         wr_ptr_q;
  logic [PW:0]           count_q;
  logic [50:0]           addr_q;
  logic                  drop_q;
  logic                  req_valid_q;
  logic                  wen_q;
  logic                  invl_q;
  logic                  ovf_q;
  logic [DATA_WIDTH-1:0] data0_q;
  logic [DATA_WIDTH-1:0] data1_q;
  logic [DATA_WIDTH-1:0] data2_q;

  logic dup_s;
  logic full_s;
  logic accept_s;
  logic push_s;
  logic pop_s;

  // Duplicate detection against the live queue window and the in-flight walk.
  always_comb begin
    dup_s = (state_q != IDLE) && (miss_addr == addr_q);
    for (int i = 0; i < DEPTH; i++) begin
      dup_s = dup_s | (({1'b0, PW'(i) - rd_ptr_q} < count_q) && (mem_q[i] == miss_addr));
    end
    full_s   = (count_q == (PW+1)'(DEPTH));
    accept_s = miss_en & ~flush & ~dup_s;
    push_s   = accept_s & ~full_s;
    pop_s    = (state_q == IDLE) & (count_q != '0) & ~flush;
  end

  // Miss FIFO storage, pointers, occupancy and overflow pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 51'd0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      ovf_q <= accept_s & full_s;
      if (flush) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push_s) begin
          mem_q[wr_ptr_q] <= miss_addr;
          wr_ptr_q        <= wr_ptr_q + PW'(1);
        end
        if (pop_s) rd_ptr_q <= rd_ptr_q + PW'(1);
        count_q <= count_q + (PW+1)'(push_s) - (PW+1)'(pop_s);
      end
    end
  end

  // Walk sequencer with registered request and TLB write outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      addr_q      <= 51'd0;
      drop_q      <= 1'b0;
      req_valid_q <= 1'b0;
      wen_q       <= 1'b0;
      invl_q      <= 1'b0;
      data0_q     <= '0;
      data1_q     <= '0;
      data2_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          wen_q  <= 1'b0;
          invl_q <= 1'b0;
          if (pop_s) begin
            addr_q      <= mem_q[rd_ptr_q];
            req_valid_q <= 1'b1;
            state_q     <= REQ;
          end
        end
        REQ: begin
          // A handshake already seen by the walker must still be drained.
          if (walk_req_ready) begin
            req_valid_q <= 1'b0;
            drop_q      <= flush;
            state_q     <= WAIT;
          end else if (flush) begin
            req_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        WAIT: begin
          if (walk_rsp_valid) begin
            drop_q <= 1'b0;
            if (drop_q | flush) begin
              state_q <= IDLE;
            end else begin
              data0_q <= walk_rsp_data0;
              data1_q <= walk_rsp_data1;
              data2_q <= walk_rsp_data2;
              invl_q  <= walk_rsp_fault;
              wen_q   <= 1'b1;
              state_q <= WRITE;
            end
          end else begin
            drop_q <= drop_q | flush;
          end
        end
        WRITE: begin
          wen_q   <= 1'b0;
          invl_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          req_valid_q <= 1'b0;
          wen_q       <= 1'b0;
          invl_q      <= 1'b0;
          drop_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign miss_full        = full_s;
  assign miss_ovf         = ovf_q;
  assign walk_req_valid   = req_valid_q;
  assign walk_req_addr    = addr_q;
  assign tlb_write_addr   = addr_q;
  assign tlb_write_data0  = data0_q;
  assign tlb_write_data1  = data1_q;
  assign tlb_write_data2  = data2_q;
  assign tlb_write_wen    = wen_q;
  assign tlb_write_invl   = invl_q;
  assign tlb_write_xstant = 1'b0;
  assign busy             = (state_q != IDLE) | (count_q != '0);

endmodule

// File: tb/tb_dtlb_miss_fill.sv
// Directed bench for dtlb_miss_fill: single miss, dedup, overflow ordering,
// fault, flush during WAIT, flush vs miss priority and reset mid-request.
module tb_dtlb_miss_fill;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          miss_en;
  logic [50:0]   miss_addr;
  logic          miss_full;
  logic          miss_ovf;
  logic          walk_req_valid;
  logic          walk_req_ready;
  logic [50:0]   walk_req_addr;
  logic          walk_rsp_valid;
  logic [DW-1:0] walk_rsp_data0;
  logic [DW-1:0] walk_rsp_data1;
  logic [DW-1:0] walk_rsp_data2;
  logic          walk_rsp_fault;
  logic [50:0]   tlb_write_addr;
  logic [DW-1:0] tlb_write_data0;
  logic [DW-1:0] tlb_write_data1;
  logic [DW-1:0] tlb_write_data2;
  logic          tlb_write_wen;
  logic          tlb_write_invl;
  logic          tlb_write_xstant;
  logic          flush;
  logic          busy;

  int checks   = 0;
  int failures = 0;
  int req_cnt  = 0;
  int wr_cnt   = 0;
  int ovf_cnt  = 0;
  int overlap  = 0;

  dtlb_miss_fill #(.DEPTH(4), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .miss_en(miss_en), .miss_addr(miss_addr),
    .miss_full(miss_full), .miss_ovf(miss_ovf),
    .walk_req_valid(walk_req_valid), .walk_req_ready(walk_req_ready),
    .walk_req_addr(walk_req_addr), .walk_rsp_valid(walk_rsp_valid),
    .walk_rsp_data0(walk_rsp_data0), .walk_rsp_data1(walk_rsp_data1),
    .walk_rsp_data2(walk_rsp_data2), .walk_rsp_fault(walk_rsp_fault),
    .tlb_write_addr(tlb_write_addr), .tlb_write_data0(tlb_write_data0),
    .tlb_write_data1(tlb_write_data1), .tlb_write_data2(tlb_write_data2),
    .tlb_write_wen(tlb_write_wen), .tlb_write_invl(tlb_write_invl),
    .tlb_write_xstant(tlb_write_xstant), .flush(flush), .busy(busy)
  );

  always #5 clk = ~clk;

  // Event counters observed at the active edge.
  always @(posedge clk) begin
    if (walk_req_valid && walk_req_ready) req_cnt <= req_cnt + 1;
    if (tlb_write_wen) wr_cnt <= wr_cnt + 1;
    if (miss_ovf) ovf_cnt <= ovf_cnt + 1;
    if (walk_req_valid && tlb_write_wen) overlap <= overlap + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Plays the page walker for one request and checks the resulting TLB write.
  task automatic serve(input string tag, input logic [50:0] a, input logic [63:0] d0,
                       input logic f, input int dly);
    int n = 0;
    walk_req_ready = 1'b1;
    while (walk_req_valid !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_req_valid"}, {63'd0, walk_req_valid}, 64'd1);
    chk({tag, "_req_addr"}, {13'd0, walk_req_addr}, {13'd0, a});
    step();
    walk_req_ready = 1'b0;
    chk({tag, "_req_dropped"}, {63'd0, walk_req_valid}, 64'd0);
    for (int k = 0; k < dly; k++) step();
    walk_rsp_valid = 1'b1;
    walk_rsp_data0 = d0;
    walk_rsp_data1 = d0 + 64'd1;
    walk_rsp_data2 = d0 + 64'd2;
    walk_rsp_fault = f;
    step();
    walk_rsp_valid = 1'b0;
    walk_rsp_fault = 1'b0;
    chk({tag, "_wen"}, {63'd0, tlb_write_wen}, 64'd1);
    chk({tag, "_waddr"}, {13'd0, tlb_write_addr}, {13'd0, a});
    chk({tag, "_d0"}, tlb_write_data0, d0);
    chk({tag, "_d1"}, tlb_write_data1, d0 + 64'd1);
    chk({tag, "_d2"}, tlb_write_data2, d0 + 64'd2);
    chk({tag, "_invl"}, {63'd0, tlb_write_invl}, {63'd0, f});
    step();
    chk({tag, "_wen_off"}, {63'd0, tlb_write_wen}, 64'd0);
  endtask

  initial begin
    int r0;
    int w0;
    int o0;
    rst = 1'b0;
    miss_en = 1'b0;
    miss_addr = 51'd0;
    walk_req_ready = 1'b0;
    walk_rsp_valid = 1'b0;
    walk_rsp_data0 = 64'd0;
    walk_rsp_data1 = 64'd0;
    walk_rsp_data2 = 64'd0;
    walk_rsp_fault = 1'b0;
    flush = 1'b0;
    step();
    step();
    chk("rst_valid", {63'd0, walk_req_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_full", {63'd0, miss_full}, 64'd0);
    chk("rst_wen", {63'd0, tlb_write_wen}, 64'd0);
    chk("rst_ovf", {63'd0, miss_ovf}, 64'd0);
    rst = 1'b1;
    step();

    // Single miss with two-cycle request latency and delayed response.
    miss_en = 1'b1;
    miss_addr = 51'h1234;
    step();
    miss_en = 1'b0;
    chk("t1_lat1_valid", {63'd0, walk_req_valid}, 64'd0);
    chk("t1_busy", {63'd0, busy}, 64'd1);
    step();
    chk("t1_lat2_valid", {63'd0, walk_req_valid}, 64'd1);
    serve("t1", 51'h1234, 64'hA, 1'b0, 3);
    chk("t1_xstant", {63'd0, tlb_write_xstant}, 64'd0);
    chk("t1_idle", {63'd0, busy}, 64'd0);

    // Same address missed three cycles in a row.
    r0 = req_cnt;
    w0 = wr_cnt;
    o0 = ovf_cnt;
    miss_en = 1'b1;
    miss_addr = 51'h55;
    step();
    step();
    step();
    miss_en = 1'b0;
    serve("t2", 51'h55, 64'h55, 1'b0, 0);
    for (int k = 0; k < 4; k++) step();
    chk("t2_reqs", 64'(req_cnt - r0), 64'd1);
    chk("t2_writes", 64'(wr_cnt - w0), 64'd1);
    chk("t2_no_ovf", 64'(ovf_cnt - o0), 64'd0);

    // Six distinct misses with the walker stalled: one in flight, four queued, one dropped.
    o0 = ovf_cnt;
    for (int i = 0; i < 6; i++) begin
      miss_en = 1'b1;
      miss_addr = 51'h100 + 51'(i);
      step();
    end
    miss_en = 1'b0;
    chk("t3_full", {63'd0, miss_full}, 64'd1);
    chk("t3_ovf_pulse", {63'd0, miss_ovf}, 64'd1);
    step();
    chk("t3_ovf_end", {63'd0, miss_ovf}, 64'd0);
    chk("t3_inflight", {13'd0, walk_req_addr}, 64'h100);
    for (int i = 0; i < 5; i++) begin
      serve($sformatf("t3_%0d", i), 51'h100 + 51'(i), 64'hB0 + 64'(i), 1'b0, 0);
    end
    step();
    chk("t3_ovf_count", 64'(ovf_cnt - o0), 64'd1);
    chk("t3_drained", {63'd0, busy}, 64'd0);
    chk("t3_not_full", {63'd0, miss_full}, 64'd0);

    // Faulting walk invalidates the entry.
    miss_en = 1'b1;
    miss_addr = 51'h777;
    step();
    miss_en = 1'b0;
    serve("t4", 51'h777, 64'hF00D, 1'b1, 1);

    // Flush while waiting for the walk response with two entries queued.
    w0 = wr_cnt;
    miss_en = 1'b1;
    miss_addr = 51'h200;
    step();
    miss_addr = 51'h201;
    step();
    miss_addr = 51'h202;
    step();
    miss_en = 1'b0;
    chk("t5_req_addr", {13'd0, walk_req_addr}, 64'h200);
    walk_req_ready = 1'b1;
    step();
    walk_req_ready = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t5_wait_busy", {63'd0, busy}, 64'd1);
    walk_rsp_valid = 1'b1;
    walk_rsp_data0 = 64'hDEAD;
    step();
    walk_rsp_valid = 1'b0;
    chk("t5_busy_clear", {63'd0, busy}, 64'd0);
    chk("t5_no_wen", {63'd0, tlb_write_wen}, 64'd0);
    for (int k = 0; k < 4; k++) step();
    chk("t5_no_writes", 64'(wr_cnt - w0), 64'd0);
    chk("t5_no_req", {63'd0, walk_req_valid}, 64'd0);

    // Flush beats a same-cycle miss.
    miss_en = 1'b1;
    miss_addr = 51'h400;
    flush = 1'b1;
    step();
    miss_en = 1'b0;
    flush = 1'b0;
    chk("t6_flush_prio", {63'd0, busy}, 64'd0);

    // Asynchronous reset in the middle of a request.
    miss_en = 1'b1;
    miss_addr = 51'h300;
    step();
    miss_en = 1'b0;
    step();
    chk("t7_req_up", {63'd0, walk_req_valid}, 64'd1);
    #1 rst = 1'b0;
    #1;
    chk("t7_rst_valid", {63'd0, walk_req_valid}, 64'd0);
    chk("t7_rst_busy", {63'd0, busy}, 64'd0);
    chk("t7_rst_addr", {13'd0, walk_req_addr}, 64'd0);
    step();
    rst = 1'b1;
    w0 = wr_cnt;
    walk_rsp_valid = 1'b1;
    walk_rsp_data0 = 64'hBAD;
    step();
    walk_rsp_valid = 1'b0;
    for (int k = 0; k < 3; k++) step();
    chk("t7_no_writes", 64'(wr_cnt - w0), 64'd0);
    chk("t7_busy", {63'd0, busy}, 64'd0);

    chk("overlap_req_wen", 64'(overlap), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dtlb_miss_fill.md
DTLB_MISS_FILL -- requirements
Module: dtlb_miss_fill

Interface
Parameters (name, default, meaning):
REQ-001 SHALL have parameter DEPTH, 4, miss-queue entries (power of 2, 2..8).
REQ-002 SHALL have parameter DATA_WIDTH, `dtlbData_width, width of one translation word.
Ports (name, direction, width, meaning):
REQ-003 SHALL have clk, input, 1, sole clock (all flops on rising edge).
REQ-004 SHALL have rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have miss_en, input, 1, lookup missed in dtlb this cycle.
REQ-006 SHALL have miss_addr, input, 51, virtual page pair index ([50:0], dtlb addr format).
REQ-007 SHALL have miss_full, output, 1, queue holds DEPTH entries.
REQ-008 SHALL have miss_ovf, output, 1, one-cycle pulse when a new miss is dropped because the queue is full.
REQ-009 SHALL have walk_req_valid/walk_req_ready, output/input, 1/1, page-walk request handshake.
REQ-010 SHALL have walk_req_addr, output, 51, page index being walked.
REQ-011 SHALL have walk_rsp_valid, input, 1, walk result present (no ready; always accepted in WAIT).
REQ-012 SHALL have walk_rsp_data0/1/2, input, DATA_WIDTH each, three consecutive translation words.
REQ-013 SHALL have walk_rsp_fault, input, 1, walk faulted.
REQ-014 SHALL have tlb_write_addr, output, 51; tlb_write_data0/1/2, output, DATA_WIDTH; tlb_write_wen, tlb_write_invl, tlb_write_xstant, output, 1 each; these drive the dtlb write port.
REQ-015 SHALL have flush, input, 1, discard all pending misses.
REQ-016 SHALL have busy, output, 1, FSM not IDLE or queue non-empty.

Function
REQ-017 SHALL keep a circular FIFO of DEPTH addresses with wrap-around rd/wr pointers and a count 0..DEPTH.
REQ-018 SHALL push miss_addr on miss_en when count<DEPTH and miss_addr equals neither a valid queued entry nor the in-flight address (dedup); duplicates are silently dropped, no ovf.
REQ-019 SHALL, on miss_en with non-duplicate address while count==DEPTH, drop it and pulse miss_ovf next cycle; a push and pop in the same cycle when full SHALL be treated as full (miss dropped).
REQ-020 SHALL implement FSM IDLE, REQ, WAIT, WRITE; IDLE->REQ when count>0, loading head into walk_req_addr (registered) and popping it.
REQ-021 SHALL hold walk_req_valid=1 and walk_req_addr stable in REQ until walk_req_ready; REQ->WAIT on valid&ready.
REQ-022 SHALL, in WAIT on walk_rsp_valid, register data0..2 and fault, then go to WRITE.
REQ-023 SHALL, in WRITE, assert tlb_write_wen for exactly one cycle with tlb_write_addr=in-flight address, tlb_write_invl=registered fault, data as registered, then return to IDLE.
REQ-024 SHALL tie tlb_write_xstant to 0.
REQ-025 SHALL, on flush, clear count and pointers next cycle; flush in REQ SHALL return FSM to IDLE without a handshake; flush in WAIT SHALL set a drop flag so the response is consumed and WRITE is skipped (WAIT->IDLE); flush in WRITE has no effect on that write.
REQ-026 SHALL give flush priority over a same-cycle miss_en (miss discarded).
REQ-027 SHALL guarantee minimum latency miss_en->walk_req_valid of 2 cycles and walk_rsp_valid->tlb_write_wen of 1 cycle.
REQ-028 SHALL never assert walk_req_valid and tlb_write_wen in the same cycle.

Reset
REQ-029 SHALL, while rst=0, force FSM=IDLE, count=0, pointers=0, drop flag=0 and all outputs 0, independent of clk.
REQ-030 SHALL discard any in-flight walk on reset; a walk_rsp_valid arriving after reset release in IDLE SHALL be ignored.

Verification
REQ-031 Single miss 0x1234, ready=1, rsp after 3 cycles data0=0xA -> one walk_req addr 0x1234, then tlb_write_wen one cycle, addr 0x1234, data0=0xA, invl=0.
REQ-032 Same address missed 3 consecutive cycles -> exactly one walk request and one TLB write.
REQ-033 DEPTH=4, ready=0, 6 distinct misses -> 1 in-flight, 4 queued, miss_full=1, one miss_ovf pulse; after release, 5 writes in push order.
REQ-034 walk_rsp_fault=1 -> tlb_write_wen=1 with tlb_write_invl=1.
REQ-035 flush during WAIT with 2 queued -> response consumed, no TLB write, count=0, busy=0 next cycle.
REQ-036 rst low mid-REQ -> walk_req_valid=0 immediately, busy=0, no write after release.
